// File: rtl/sim_vga_timing_ctrl.sv
// VGA timing controller and pixel scheduler for the simulated VGA path.
// Ports: clk_i/rst_in (sync active-low), en_i, pix_valid_i/pix_rgb_i/pix_ready_o
//        upstream handshake, x_o/y_o/de_o/line_start_o/frame_start_o timing,
//        r_o/g_o/b_o/hs_o/vs_o to simio_vga, underflow_o/clr_underflow_i sticky flag.
module sim_vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_in,
    input  logic          en_i,
    input  logic          pix_valid_i,
    input  logic [5:0]    pix_rgb_i,
    output logic          pix_ready_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          de_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic [1:0]    r_o,
    output logic [1:0]    g_o,
    output logic [1:0]    b_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          underflow_o,
    input  logic          clr_underflow_i
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [5:0]    rgb_q;
    logic          h_wrap;
    logic          v_wrap;
    logic          de;
    logic          xfer;
    logic          miss;
    logic          h_sync;
    logic          v_sync;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        de     = en_i && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        xfer   = de && pix_valid_i;
        miss   = de && !pix_valid_i;
        h_sync = (h_cnt >= H_SS) && (h_cnt < H_SE);
        v_sync = (v_cnt >= V_SS) && (v_cnt < V_SE);
    end

    assign de_o          = de;
    assign pix_ready_o   = de;
    assign x_o           = h_cnt;
    assign y_o           = v_cnt;
    assign line_start_o  = en_i && (h_cnt == '0) && (v_cnt < V_ACT);
    assign frame_start_o = en_i && (h_cnt == '0) && (v_cnt == '0);
    assign r_o           = rgb_q[5:4];
    assign g_o           = rgb_q[3:2];
    assign b_o           = rgb_q[1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            rgb_q       <= '0;
            hs_o        <= ~HS_POL;
            vs_o        <= ~VS_POL;
            underflow_o <= 1'b0;
        end else begin
            if (!en_i) begin
                // Disabled: park at frame origin so re-enable starts a frame.
                h_cnt <= '0;
                v_cnt <= '0;
                rgb_q <= '0;
                hs_o  <= ~HS_POL;
                vs_o  <= ~VS_POL;
            end else begin
                h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
                if (h_wrap) begin
                    v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
                end
                // A missed slot is emitted black and never retried.
                rgb_q <= xfer ? pix_rgb_i : '0;
                hs_o  <= h_sync ? HS_POL : ~HS_POL;
                vs_o  <= v_sync ? VS_POL : ~VS_POL;
            end
            // Set has priority over clear.
            if (miss) begin
                underflow_o <= 1'b1;
            end else if (clr_underflow_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sim_vga_timing_ctrl.sv
// Scoreboard bench for sim_vga_timing_ctrl on a small 15x8 raster.
// Stimulus pushes expected values from a frame-position model; a monitor compares.
module tb_sim_vga_timing_ctrl;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int CW = 4;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          valid;
    logic [5:0]    pix;
    logic          clr;
    logic          ready;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          de;
    logic          ls;
    logic          fs;
    logic [1:0]    r;
    logic [1:0]    g;
    logic [1:0]    b;
    logic          hs;
    logic          vs;
    logic          unf;

    sim_vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut (
        .clk_i(clk),
        .rst_in(rst_n),
        .en_i(en),
        .pix_valid_i(valid),
        .pix_rgb_i(pix),
        .pix_ready_o(ready),
        .x_o(x),
        .y_o(y),
        .de_o(de),
        .line_start_o(ls),
        .frame_start_o(fs),
        .r_o(r),
        .g_o(g),
        .b_o(b),
        .hs_o(hs),
        .vs_o(vs),
        .underflow_o(unf),
        .clr_underflow_i(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit de;
        bit ls;
        bit fs;
        int rgb;
        bit hs;
        bit vs;
        bit unf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Model: position within the frame plus the values the output regs hold.
    int pos = 0;
    int m_rgb = 0;
    bit m_hs = 1'b1;
    bit m_vs = 1'b1;
    bit m_unf = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic step(bit r_i, bit e_i, bit v_i, logic [5:0] p_i, bit c_i);
        exp_t e;
        int   h;
        int   vl;
        bit   act;
        @(posedge clk);
        #1;
        rst_n = r_i;
        en    = e_i;
        valid = v_i;
        pix   = p_i;
        clr   = c_i;
        h   = pos % HT;
        vl  = pos / HT;
        act = e_i && (h < HA) && (vl < VA);
        e.x   = h;
        e.y   = vl;
        e.de  = act;
        e.ls  = e_i && (h == 0) && (vl < VA);
        e.fs  = e_i && (pos == 0);
        e.rgb = m_rgb;
        e.hs  = m_hs;
        e.vs  = m_vs;
        e.unf = m_unf;
        q.push_back(e);
        if (!r_i) begin
            pos = 0; m_rgb = 0; m_hs = 1'b1; m_vs = 1'b1; m_unf = 1'b0;
        end else if (!e_i) begin
            pos = 0; m_rgb = 0; m_hs = 1'b1; m_vs = 1'b1;
            if (c_i) m_unf = 1'b0;
        end else begin
            m_rgb = (act && v_i) ? int'(p_i) : 0;
            m_hs  = !(h >= HA + HF && h < HA + HF + HSW);
            m_vs  = !(vl >= VA + VF && vl < VA + VF + VSW);
            if (act && !v_i) m_unf = 1'b1;
            else if (c_i) m_unf = 1'b0;
            pos = (pos + 1) % (HT * VT);
        end
    endtask

    // Pixel source sending the current x coordinate as colour.
    task automatic src(bit v_i, bit c_i);
        step(1'b1, 1'b1, v_i, 6'(pos % HT), c_i);
    endtask

    task automatic run_to(int target);
        while (pos != target) src(1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("x_o", 32'(x), 32'(e.x));
                chk("y_o", 32'(y), 32'(e.y));
                chk("de_o", 32'(de), 32'(e.de));
                chk("pix_ready_o", 32'(ready), 32'(e.de));
                chk("line_start_o", 32'(ls), 32'(e.ls));
                chk("frame_start_o", 32'(fs), 32'(e.fs));
                chk("rgb", 32'({r, g, b}), 32'(e.rgb));
                chk("hs_o", 32'(hs), 32'(e.hs));
                chk("vs_o", 32'(vs), 32'(e.vs));
                chk("underflow_o", 32'(unf), 32'(e.unf));
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; pix = '0; clr = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b1, 6'h3f, 1'b0);
        // Two clean frames.
        for (int i = 0; i < 2 * HT * VT; i++) src(1'b1, 1'b0);
        // Miss at x=3,y=2, then clear.
        run_to(2 * HT + 3);
        src(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) src(1'b1, 1'b0);
        src(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) src(1'b1, 1'b0);
        // Clear coincident with a new miss.
        run_to(3 * HT + 1);
        src(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) src(1'b1, 1'b0);
        // Disable mid-line at h=5,v=1.
        run_to(HT + 5);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 6'h15, 1'b0);
        for (int i = 0; i < 20; i++) src(1'b1, 1'b0);
        // Reset during hsync at h=11 with underflow still set.
        run_to(11);
        step(1'b0, 1'b1, 1'b1, 6'h2a, 1'b0);
        for (int i = 0; i < 20; i++) src(1'b1, 1'b0);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(99) != 0,
                 $urandom_range(99) >= 3,
                 $urandom_range(99) < 90,
                 6'($urandom),
                 $urandom_range(99) < 5);
        end
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
